// File: rtl/id_stage_fwd.sv
// MIPS decode stage: IF/ID register, instruction hold, write-first register file,
// EX/MEM/WB operand forwarding, load-use stall request and in-ID branch resolution.
module id_stage_fwd #(
    parameter int DATA_W         = 32,
    parameter int PC_W           = 32,
    parameter int STALL_W        = 6,
    parameter bit LOAD_STALL_MEM = 1'b0,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               if_valid,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [31:0]        inst_sram_rdata,
    input  logic               wb_we,
    input  logic [4:0]         wb_waddr,
    input  logic [DATA_W-1:0]  wb_wdata,
    input  logic               ex_we,
    input  logic [4:0]         ex_waddr,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic               ex_is_load,
    input  logic               mem_we,
    input  logic [4:0]         mem_waddr,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_is_load,
    output logic               stallreq,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [31:0]        id_inst,
    output logic [11:0]        alu_op,
    output logic [2:0]         sel_alu_src1,
    output logic [3:0]         sel_alu_src2,
    output logic               mem_en,
    output logic [3:0]         mem_wen,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic               sel_rf_res,
    output logic [DATA_W-1:0]  data1,
    output logic [DATA_W-1:0]  data2,
    output logic               br_e,
    output logic [PC_W-1:0]    br_addr,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE     = 6'h05, OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                           OP_LW      = 6'h23, OP_SW  = 6'h2b;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
                           F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                           F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;
    localparam logic [11:0] ALU_ADD = 12'h800, ALU_SUB = 12'h400, ALU_SLT = 12'h200,
                            ALU_SLTU = 12'h100, ALU_AND = 12'h080, ALU_NOR = 12'h040,
                            ALU_OR = 12'h020, ALU_XOR = 12'h010, ALU_SLL = 12'h008,
                            ALU_SRL = 12'h004, ALU_SRA = 12'h002, ALU_LUI = 12'h001;
    localparam logic [2:0] SRC1_SA = 3'b100, SRC1_PC = 3'b010, SRC1_RS = 3'b001;
    localparam logic [3:0] SRC2_ZEXT = 4'b1000, SRC2_8 = 4'b0100, SRC2_SEXT = 4'b0010, SRC2_RT = 4'b0001;

    logic              if_id_v;
    logic [PC_W-1:0]   if_id_pc;
    logic              hold_v;
    logic [31:0]       inst_hold;
    logic [DATA_W-1:0] regs [32];

    // NOTE: every clocked block uses <= so all registers sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_v  <= 1'b0;
            if_id_pc <= '0;
        end else if (flush || (stall[1] && !stall[2])) begin
            if_id_v  <= 1'b0;
            if_id_pc <= '0;
        end else if (!stall[1]) begin
            if_id_v  <= if_valid;
            if_id_pc <= if_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     hold_v <= 1'b0;
        else if (flush || !stall[2]) hold_v <= 1'b0;
        else                         hold_v <= 1'b1;
    end

    // NOTE: inst_hold and the register file carry no reset; their contents are only
    // observed behind hold_v or after a write, so a reset network would buy nothing.
    always_ff @(posedge clk) begin
        if (stall[2] && !hold_v) inst_hold <= inst_sram_rdata;
    end

    always_ff @(posedge clk) begin
        if (wb_we && wb_waddr != 5'd0) regs[wb_waddr] <= wb_wdata;
    end

    logic [31:0] inst;
    assign inst    = hold_v ? inst_hold : inst_sram_rdata;
    assign id_inst = if_id_v ? inst : 32'd0;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    assign opcode = id_inst[31:26];
    assign rs     = id_inst[25:21];
    assign rt     = id_inst[20:16];
    assign rd     = id_inst[15:11];
    assign imm    = id_inst[15:0];
    assign funct  = id_inst[5:0];

    logic [11:0] d_alu;
    logic [2:0]  d_src1;
    logic [3:0]  d_src2, d_mem_wen;
    logic [4:0]  d_waddr;
    logic        d_mem_en, d_rf_we, d_rf_res;
    logic        is_beq, is_bne, is_j, is_jal, is_jr, uses_rs, uses_rt;

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        d_alu = '0; d_src1 = '0; d_src2 = '0; d_mem_en = 1'b0; d_mem_wen = '0;
        d_rf_we = 1'b0; d_waddr = '0; d_rf_res = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
        uses_rs = 1'b1; uses_rt = 1'b0;
        if (if_id_v) begin
            case (opcode)
                OP_SPECIAL: begin
                    uses_rt = 1'b1;
                    case (funct)
                        F_ADDU: d_alu = ALU_ADD;   F_SUBU: d_alu = ALU_SUB;
                        F_SLT:  d_alu = ALU_SLT;   F_SLTU: d_alu = ALU_SLTU;
                        F_AND:  d_alu = ALU_AND;   F_NOR:  d_alu = ALU_NOR;
                        F_OR:   d_alu = ALU_OR;    F_XOR:  d_alu = ALU_XOR;
                        F_SLL:  d_alu = ALU_SLL;   F_SRL:  d_alu = ALU_SRL;
                        F_SRA:  d_alu = ALU_SRA;   F_JR:   is_jr = 1'b1;
                        default: ;
                    endcase
                    if (d_alu != '0) begin
                        d_rf_we = 1'b1;
                        d_waddr = rd;
                        d_src1  = ((d_alu & (ALU_SLL | ALU_SRL | ALU_SRA)) != '0) ? SRC1_SA : SRC1_RS;
                        d_src2  = SRC2_RT;
                    end
                end
                OP_ORI:   begin d_alu = ALU_OR;  d_src1 = SRC1_RS; d_src2 = SRC2_ZEXT; d_rf_we = 1'b1; d_waddr = rt; end
                OP_LUI:   begin d_alu = ALU_LUI; d_src2 = SRC2_ZEXT; d_rf_we = 1'b1; d_waddr = rt; uses_rs = 1'b0; end
                OP_ADDIU: begin d_alu = ALU_ADD; d_src1 = SRC1_RS; d_src2 = SRC2_SEXT; d_rf_we = 1'b1; d_waddr = rt; end
                OP_LW: begin
                    d_alu = ALU_ADD; d_src1 = SRC1_RS; d_src2 = SRC2_SEXT;
                    d_rf_we = 1'b1; d_waddr = rt; d_mem_en = 1'b1; d_rf_res = 1'b1;
                end
                OP_SW: begin
                    d_alu = ALU_ADD; d_src1 = SRC1_RS; d_src2 = SRC2_SEXT;
                    d_mem_en = 1'b1; d_mem_wen = 4'b1111; uses_rt = 1'b1;
                end
                OP_BEQ: begin is_beq = 1'b1; uses_rt = 1'b1; end
                OP_BNE: begin is_bne = 1'b1; uses_rt = 1'b1; end
                OP_J:   begin is_j = 1'b1; uses_rs = 1'b0; end
                OP_JAL: begin
                    is_jal = 1'b1; uses_rs = 1'b0;
                    d_alu = ALU_ADD; d_src1 = SRC1_PC; d_src2 = SRC2_8; d_rf_we = 1'b1; d_waddr = 5'd31;
                end
                default: ;
            endcase
        end
    end

    function automatic logic hit(input logic we, input logic [4:0] waddr, input logic [4:0] src);
        return we && (waddr == src) && (src != 5'd0);
    endfunction

    logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
    assign ex_rs  = hit(ex_we, ex_waddr, rs);
    assign ex_rt  = hit(ex_we, ex_waddr, rt);
    assign mem_rs = hit(mem_we, mem_waddr, rs);
    assign mem_rt = hit(mem_we, mem_waddr, rt);
    assign wb_rs  = hit(wb_we, wb_waddr, rs);
    assign wb_rt  = hit(wb_we, wb_waddr, rt);

    assign data1 = (rs == 5'd0) ? '0 : ex_rs ? ex_wdata : mem_rs ? mem_wdata : wb_rs ? wb_wdata : regs[rs];
    assign data2 = (rt == 5'd0) ? '0 : ex_rt ? ex_wdata : mem_rt ? mem_wdata : wb_rt ? wb_wdata : regs[rt];

    logic ex_dep, mem_dep;
    assign ex_dep   = ex_is_load && ((uses_rs && ex_rs) || (uses_rt && ex_rt));
    assign mem_dep  = LOAD_STALL_MEM && mem_is_load && ((uses_rs && mem_rs) || (uses_rt && mem_rt));
    assign stallreq = if_id_v && (ex_dep || mem_dep);

    assign id_valid     = if_id_v && !stallreq;
    assign id_pc        = if_id_pc;
    assign alu_op       = d_alu;
    assign sel_alu_src1 = d_src1;
    assign sel_alu_src2 = d_src2;
    assign mem_en       = d_mem_en && !stallreq;
    assign mem_wen      = stallreq ? 4'b0000 : d_mem_wen;
    assign rf_we        = d_rf_we && !stallreq;
    assign rf_waddr     = d_waddr;
    assign sel_rf_res   = d_rf_res;

    logic [PC_W-1:0] pc4, tgt;
    logic            take;
    assign pc4  = if_id_pc + PC_W'(4);
    assign take = (is_beq && data1 == data2) || (is_bne && data1 != data2) || is_j || is_jal || is_jr;
    assign tgt  = is_jr ? PC_W'(data1)
                : (is_j || is_jal) ? {pc4[PC_W-1:28], id_inst[25:0], 2'b00}
                : pc4 + {{(PC_W-18){imm[15]}}, imm, 2'b00};
    assign br_e    = take && id_valid;
    assign br_addr = br_e ? tgt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 stall_cnt <= '0;
        else if (stallreq && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
    end

    // Stall bits other than the IF/ID and ID/EX holds belong to other stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[STALL_W-1:3], stall[0]};
endmodule

// File: tb/tb_id_stage_fwd.sv
// Scoreboard bench for id_stage_fwd: expectations are queued as stimulus is driven
// and compared against the DUT once the combinational outputs have settled.
module tb_id_stage_fwd;
    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0, if_valid = 1'b0;
    logic [31:0] if_pc = '0, inst_sram_rdata = '0;
    logic        wb_we = 1'b0, ex_we = 1'b0, ex_is_load = 1'b0, mem_we = 1'b0, mem_is_load = 1'b0;
    logic [4:0]  wb_waddr = '0, ex_waddr = '0, mem_waddr = '0;
    logic [31:0] wb_wdata = '0, ex_wdata = '0, mem_wdata = '0;
    logic        stallreq, id_valid, mem_en, rf_we, sel_rf_res, br_e;
    logic [31:0] id_pc, id_inst, data1, data2, br_addr;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2, mem_wen;
    logic [4:0]  rf_waddr;
    logic [15:0] stall_cnt;

    id_stage_fwd dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
        .inst_sram_rdata(inst_sram_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
        .stallreq(stallreq), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .alu_op(alu_op), .sel_alu_src1(sel_alu_src1), .sel_alu_src2(sel_alu_src2),
        .mem_en(mem_en), .mem_wen(mem_wen), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .sel_rf_res(sel_rf_res), .data1(data1), .data2(data2), .br_e(br_e), .br_addr(br_addr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef enum {S_DATA1, S_DATA2, S_ALU, S_WADDR, S_RFWE, S_SREQ, S_SCNT, S_VALID, S_PC,
                  S_INST, S_BRE, S_BRA, S_SRC1, S_SRC2, S_MEMEN, S_MEMWEN, S_RFRES} sel_e;
    typedef struct {
        sel_e        sel;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [11:0] A_ADD = 12'h800, A_OR = 12'h020;

    function automatic logic [63:0] observe(input sel_e s);
        case (s)
            S_DATA1:  return 64'(data1);
            S_DATA2:  return 64'(data2);
            S_ALU:    return 64'(alu_op);
            S_WADDR:  return 64'(rf_waddr);
            S_RFWE:   return 64'(rf_we);
            S_SREQ:   return 64'(stallreq);
            S_SCNT:   return 64'(stall_cnt);
            S_VALID:  return 64'(id_valid);
            S_PC:     return 64'(id_pc);
            S_INST:   return 64'(id_inst);
            S_BRE:    return 64'(br_e);
            S_BRA:    return 64'(br_addr);
            S_SRC1:   return 64'(sel_alu_src1);
            S_SRC2:   return 64'(sel_alu_src2);
            S_MEMEN:  return 64'(mem_en);
            S_MEMWEN: return 64'(mem_wen);
            default:  return 64'(sel_rf_res);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic expect_val(input sel_e s, input logic [63:0] v, input string tag);
        exp_t e;
        e.sel = s; e.val = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        @(posedge clk);
        #1;
        inst_sram_rdata = inst;
    endtask

    task automatic clear_fwd();
        ex_we = 1'b0; ex_is_load = 1'b0; mem_we = 1'b0; mem_is_load = 1'b0; wb_we = 1'b0;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    logic [31:0] inst_a, inst_lu;

    initial begin
        // Reset state
        #12;
        expect_val(S_VALID, 0, "rst_valid");
        expect_val(S_PC, 0, "rst_pc");
        expect_val(S_INST, 0, "rst_inst");
        expect_val(S_SCNT, 0, "rst_cnt");
        expect_val(S_ALU, 0, "rst_alu");
        expect_val(S_BRA, 0, "rst_bra");
        drain();
        rst = 1'b0;

        // addiu $1,$0,5 then ori $2,$1,3 with the addiu result in EX
        issue(32'h0, enc_i(6'h09, 5'd0, 5'd1, 16'd5));
        expect_val(S_VALID, 1, "addiu_valid");
        expect_val(S_ALU, A_ADD, "addiu_alu");
        expect_val(S_WADDR, 1, "addiu_waddr");
        expect_val(S_SRC2, 4'b0010, "addiu_src2");
        expect_val(S_DATA1, 0, "addiu_data1");
        drain();
        issue(32'h4, enc_i(6'h0d, 5'd1, 5'd2, 16'd3));
        ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'd5;
        expect_val(S_DATA1, 5, "ori_fwd_ex");
        expect_val(S_ALU, A_OR, "ori_alu");
        expect_val(S_WADDR, 2, "ori_waddr");
        expect_val(S_SRC2, 4'b1000, "ori_src2");
        drain();

        // Forwarding priority on $3
        issue(32'h8, enc_r(5'd3, 5'd0, 5'd7, 6'h21));
        clear_fwd();
        ex_we = 1'b1;  ex_waddr = 5'd3;  ex_wdata = 32'd7;
        mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'd9;
        wb_we = 1'b1;  wb_waddr = 5'd3;  wb_wdata = 32'd11;
        expect_val(S_DATA1, 7, "prio_ex");
        drain();
        ex_we = 1'b0;
        expect_val(S_DATA1, 9, "prio_mem");
        drain();
        mem_we = 1'b0;
        expect_val(S_DATA1, 11, "prio_wb");
        drain();
        // The WB write to $3 commits on this edge; $0 never forwards
        issue(32'hc, enc_r(5'd0, 5'd0, 5'd8, 6'h21));
        clear_fwd();
        ex_we = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hdead;
        expect_val(S_DATA1, 0, "zero_src1");
        expect_val(S_DATA2, 0, "zero_src2");
        drain();
        ex_we = 1'b0;
        issue(32'h10, enc_r(5'd3, 5'd3, 5'd9, 6'h21));
        expect_val(S_DATA1, 11, "rf_read1");
        expect_val(S_DATA2, 11, "rf_read2");
        drain();

        // Unknown opcode, sw and lw controls
        issue(32'h14, {6'h3f, 26'h0});
        expect_val(S_ALU, 0, "unk_alu");
        expect_val(S_RFWE, 0, "unk_rfwe");
        drain();
        issue(32'h18, enc_i(6'h2b, 5'd1, 5'd2, 16'd4));
        expect_val(S_MEMEN, 1, "sw_memen");
        expect_val(S_MEMWEN, 4'hf, "sw_wen");
        expect_val(S_RFWE, 0, "sw_rfwe");
        drain();
        issue(32'h1c, enc_i(6'h23, 5'd1, 5'd4, 16'd0));
        expect_val(S_MEMWEN, 0, "lw_wen");
        expect_val(S_RFRES, 1, "lw_rfres");
        expect_val(S_WADDR, 4, "lw_waddr");
        drain();

        // Load-use hazard, then the load moves to MEM
        inst_lu = enc_r(5'd4, 5'd6, 5'd5, 6'h21);
        issue(32'h20, inst_lu);
        ex_we = 1'b1; ex_waddr = 5'd4; ex_is_load = 1'b1; ex_wdata = 32'hbad;
        expect_val(S_SREQ, 1, "lu_stallreq");
        expect_val(S_RFWE, 0, "lu_rfwe");
        expect_val(S_VALID, 0, "lu_valid");
        drain();
        stall = 6'b000110;
        @(posedge clk);
        #1;
        clear_fwd();
        mem_we = 1'b1; mem_waddr = 5'd4; mem_is_load = 1'b1; mem_wdata = 32'h1234;
        inst_sram_rdata = 32'hffff_ffff;
        expect_val(S_SCNT, 1, "lu_cnt");
        expect_val(S_SREQ, 0, "lu_mem_nostall");
        expect_val(S_DATA1, 32'h1234, "lu_mem_fwd");
        expect_val(S_INST, inst_lu, "lu_hold_inst");
        drain();
        stall = 6'b0;
        clear_fwd();

        // Branches
        issue(32'h100, enc_i(6'h04, 5'd0, 5'd0, 16'hffff));
        expect_val(S_BRE, 1, "beq_e");
        expect_val(S_BRA, 32'h100, "beq_addr");
        drain();
        issue(32'h104, enc_i(6'h05, 5'd0, 5'd0, 16'hffff));
        expect_val(S_BRE, 0, "bne_eq_e");
        expect_val(S_BRA, 0, "bne_eq_addr");
        drain();
        issue(32'h200, enc_i(6'h05, 5'd9, 5'd0, 16'd4));
        ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'd1;
        expect_val(S_BRE, 1, "bne_ne_e");
        expect_val(S_BRA, 32'h214, "bne_ne_addr");
        drain();
        clear_fwd();

        // Instruction hold across a 3-cycle ID/EX stall, then a bubble
        inst_a = enc_i(6'h0d, 5'd1, 5'd2, 16'h55);
        issue(32'h300, inst_a);
        stall = 6'b000110;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            inst_sram_rdata = $urandom | 32'h8000_0000;
            expect_val(S_INST, inst_a, $sformatf("hold_inst%0d", i));
            expect_val(S_PC, 32'h300, $sformatf("hold_pc%0d", i));
            drain();
        end
        stall = 6'b000010;
        @(posedge clk);
        #1;
        expect_val(S_VALID, 0, "bubble_valid");
        expect_val(S_INST, 0, "bubble_inst");
        expect_val(S_RFWE, 0, "bubble_rfwe");
        drain();
        stall = 6'b0;

        // Flush squashes the IF/ID register
        issue(32'h400, enc_i(6'h09, 5'd0, 5'd1, 16'd1));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        expect_val(S_VALID, 0, "flush_valid");
        expect_val(S_PC, 0, "flush_pc");
        drain();

        // jal
        issue(32'h0040_0000, {6'h03, 26'h010_0010});
        expect_val(S_BRE, 1, "jal_e");
        expect_val(S_BRA, 32'h0040_0040, "jal_addr");
        expect_val(S_WADDR, 31, "jal_waddr");
        expect_val(S_SRC1, 3'b010, "jal_src1");
        expect_val(S_SRC2, 4'b0100, "jal_src2");
        expect_val(S_ALU, A_ADD, "jal_alu");
        drain();

        // Reset asserted in the middle of a load-use stall
        issue(32'h500, inst_lu);
        ex_we = 1'b1; ex_waddr = 5'd4; ex_is_load = 1'b1;
        stall = 6'b000110;
        @(posedge clk);
        #1;
        expect_val(S_SCNT, 2, "mid_cnt");
        expect_val(S_SREQ, 1, "mid_stallreq");
        drain();
        #2;
        rst = 1'b1;
        stall = 6'b0;
        expect_val(S_VALID, 0, "mrst_valid");
        expect_val(S_PC, 0, "mrst_pc");
        expect_val(S_INST, 0, "mrst_inst");
        expect_val(S_SCNT, 0, "mrst_cnt");
        expect_val(S_SREQ, 0, "mrst_stallreq");
        expect_val(S_RFWE, 0, "mrst_rfwe");
        expect_val(S_BRE, 0, "mrst_bre");
        expect_val(S_ALU, 0, "mrst_alu");
        drain();
        clear_fwd();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
